// File: rtl/dff_vec_checker_pkg.sv
// -----------------------------------------------------------------------------
// dff_chk_pkg
// Shared definitions for the storage-element vector checker:
//   - ERR_W / ERR_MAX : width and saturation value of the mismatch counter
//   - VEC_TABLE       : replayed {rst_n, d} stimulus, entry 0 applied first
//   - state_t         : checker FSM states
// -----------------------------------------------------------------------------
package dff_chk_pkg;

    localparam int ERR_W   = 5;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    // {rst_n, d}. Expected q is rst_n & d, so entries 3, 4 and 6 expect a 1.
    localparam logic [1:0] VEC_TABLE [0:7] = '{
        2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b00
    };

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        HOLD,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/dff_vec_checker_if.sv
// -----------------------------------------------------------------------------
// dff_vec_checker_if
// Bus between the checker and the three storage elements under test.
//   dut_rst_n, dut_d        : stimulus fanned out to d_latch, dff_asyn, dff_syn
//   q_latch, q_dff_asyn,
//   q_dff_syn               : q outputs returned from each element
// master = checker side, slave = element side.
// -----------------------------------------------------------------------------
interface dff_vec_checker_if;

    logic dut_rst_n;
    logic dut_d;
    logic q_latch;
    logic q_dff_asyn;
    logic q_dff_syn;

    modport master (
        output dut_rst_n,
        output dut_d,
        input  q_latch,
        input  q_dff_asyn,
        input  q_dff_syn
    );

    modport slave (
        input  dut_rst_n,
        input  dut_d,
        output q_latch,
        output q_dff_asyn,
        output q_dff_syn
    );

endinterface

// File: rtl/dff_vec_checker.sv
// -----------------------------------------------------------------------------
// dff_vec_checker
// Replays VEC_TABLE into d_latch / dff_asyn / dff_syn, waits a settle window,
// samples each q against rst_n & d and accumulates mismatches.
// Ports:
//   clk      : system clock (also the clock of the elements under test)
//   rst      : synchronous active-high reset
//   start    : one-cycle pulse, accepted in IDLE or DONE
//   bus      : stimulus out / q in (dff_vec_checker_if.master)
//   busy     : run in progress
//   done     : run finished, held until the next accepted start
//   pass     : done with zero mismatches
//   err_cnt  : total mismatches, saturating at ERR_MAX
//   err_mask : sticky per-element fail flags {syn, asyn, latch}
//   vec_idx  : index of the vector currently applied
// Each vector takes HOLD_CYC+2 cycles: APPLY, HOLD x HOLD_CYC, SAMPLE.
// -----------------------------------------------------------------------------
module dff_vec_checker
    import dff_chk_pkg::*;
#(
    parameter int NUM_VEC  = 7,
    parameter int HOLD_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    dff_vec_checker_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [2:0]           err_mask,
    output logic [2:0]           vec_idx
);

    state_t             state_reg,     state_next;
    logic [2:0]         vec_idx_reg,   vec_idx_next;
    logic [7:0]         hold_cnt_reg,  hold_cnt_next;
    logic               rst_n_reg,     rst_n_next;
    logic               d_reg,         d_next;
    logic [ERR_W-1:0]   err_cnt_reg,   err_cnt_next;
    logic [2:0]         err_mask_reg,  err_mask_next;

    logic               exp_q;
    logic [2:0]         miss;
    logic [1:0]         miss_cnt;
    logic [ERR_W:0]     err_sum;

    // Every element should settle to rst_n & d within the hold window.
    assign exp_q    = rst_n_reg & d_reg;
    assign miss     = {bus.q_dff_syn  != exp_q,
                       bus.q_dff_asyn != exp_q,
                       bus.q_latch    != exp_q};
    assign miss_cnt = {1'b0, miss[0]} + {1'b0, miss[1]} + {1'b0, miss[2]};
    // One extra bit so the sum of up to three misses can be saturated.
    assign err_sum  = {1'b0, err_cnt_reg} + {{(ERR_W-1){1'b0}}, miss_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            vec_idx_reg  <= '0;
            hold_cnt_reg <= '0;
            rst_n_reg    <= 1'b0;
            d_reg        <= 1'b0;
            err_cnt_reg  <= '0;
            err_mask_reg <= '0;
        end else begin
            state_reg    <= state_next;
            vec_idx_reg  <= vec_idx_next;
            hold_cnt_reg <= hold_cnt_next;
            rst_n_reg    <= rst_n_next;
            d_reg        <= d_next;
            err_cnt_reg  <= err_cnt_next;
            err_mask_reg <= err_mask_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        vec_idx_next  = vec_idx_reg;
        hold_cnt_next = hold_cnt_reg;
        rst_n_next    = rst_n_reg;
        d_next        = d_reg;
        err_cnt_next  = err_cnt_reg;
        err_mask_next = err_mask_reg;

        case (state_reg)
            IDLE, DONE: begin
                // Stimulus keeps the last vector; only the result is cleared.
                if (start) begin
                    state_next    = APPLY;
                    vec_idx_next  = '0;
                    err_cnt_next  = '0;
                    err_mask_next = '0;
                end
            end
            APPLY: begin
                {rst_n_next, d_next} = VEC_TABLE[vec_idx_reg];
                hold_cnt_next        = '0;
                state_next           = HOLD;
            end
            HOLD: begin
                if (hold_cnt_reg == 8'(HOLD_CYC - 1)) begin
                    state_next = SAMPLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            SAMPLE: begin
                err_mask_next = err_mask_reg | miss;
                err_cnt_next  = (err_sum > (ERR_W + 1)'(ERR_MAX))
                              ? ERR_W'(ERR_MAX) : err_sum[ERR_W-1:0];
                if (vec_idx_reg == 3'(NUM_VEC - 1)) begin
                    state_next = DONE;
                end else begin
                    vec_idx_next = vec_idx_reg + 3'd1;
                    state_next   = APPLY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.dut_rst_n = rst_n_reg;
    assign bus.dut_d     = d_reg;
    assign busy          = (state_reg == APPLY) || (state_reg == HOLD) ||
                           (state_reg == SAMPLE);
    assign done          = (state_reg == DONE);
    assign pass          = done && (err_cnt_reg == '0);
    assign err_cnt       = err_cnt_reg;
    assign err_mask      = err_mask_reg;
    assign vec_idx       = vec_idx_reg;

endmodule

// File: tb/tb_dff_vec_checker.sv
// -----------------------------------------------------------------------------
// tb_dff_vec_checker
// Drives dff_vec_checker against behavioural d_latch / dff_asyn / dff_syn
// models whose q outputs can be overridden with stuck values.
// -----------------------------------------------------------------------------
module tb_dff_vec_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
    logic [2:0] err_mask;
    logic [2:0] vec_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-written copy of the stimulus table, {rst_n, d}.
    logic [1:0] exp_tab [0:6] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};

    // Per-element override: bit0 latch, bit1 asyn, bit2 syn.
    logic [2:0] frc_en  = 3'b000;
    logic [2:0] frc_val = 3'b000;

    logic q_latch_m, q_asyn_m, q_syn_m;

    dff_vec_checker_if bus ();

    dff_vec_checker #(.NUM_VEC(7), .HOLD_CYC(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .err_mask (err_mask),
        .vec_idx  (vec_idx)
    );

    always #5 clk = ~clk;

    // Behavioural storage elements.
    always @(clk or bus.dut_rst_n or bus.dut_d) begin
        if (!bus.dut_rst_n)  q_latch_m = 1'b0;
        else if (clk)        q_latch_m = bus.dut_d;
    end

    always @(posedge clk or negedge bus.dut_rst_n) begin
        if (!bus.dut_rst_n) q_asyn_m <= 1'b0;
        else                q_asyn_m <= bus.dut_d;
    end

    always @(posedge clk) begin
        q_syn_m <= bus.dut_rst_n ? bus.dut_d : 1'b0;
    end

    assign bus.q_latch    = frc_en[0] ? frc_val[0] : q_latch_m;
    assign bus.q_dff_asyn = frc_en[1] ? frc_val[1] : q_asyn_m;
    assign bus.q_dff_syn  = frc_en[2] ? frc_val[2] : q_syn_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles until done, starting from cyc0; -1 if it never arrives.
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_dut_rst_n got=%b want=0", bus.dut_rst_n); end
        n_checks++; if (bus.dut_d !== 1'b0)     begin n_fail++; $display("FAIL reset_dut_d got=%b want=0", bus.dut_d); end
        n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0)          begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++; if (pass !== 1'b0)          begin n_fail++; $display("FAIL reset_pass got=%b want=0", pass); end
        n_checks++; if (err_cnt !== 5'd0)       begin n_fail++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        n_checks++; if (err_mask !== 3'b000)    begin n_fail++; $display("FAIL reset_err_mask got=%b want=000", err_mask); end
        n_checks++; if (vec_idx !== 3'd0)       begin n_fail++; $display("FAIL reset_vec_idx got=%0d want=0", vec_idx); end
        rst = 1'b0;
        tick();
        $display("reset: outputs idle");
    endtask

    // Walks each vector: just after its APPLY edge the stimulus must match.
    task automatic test_good_run();
        frc_en = 3'b000;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++; if ({bus.dut_rst_n, bus.dut_d} !== exp_tab[i]) begin n_fail++; $display("FAIL apply_vec%0d got=%b want=%b", i, {bus.dut_rst_n, bus.dut_d}, exp_tab[i]); end
            n_checks++; if (vec_idx !== 3'(i)) begin n_fail++; $display("FAIL vec_idx_vec%0d got=%0d want=%0d", i, vec_idx, i); end
            n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL busy_vec%0d got=%b want=1", i, busy); end
            $display("vector %0d applied rst_n=%b d=%b", i, bus.dut_rst_n, bus.dut_d);
            repeat (2) tick();
            n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL early_done_vec%0d got=%b want=0", i, done); end
            tick();
        end
        n_checks++; if (done !== 1'b1)       begin n_fail++; $display("FAIL good_done got=%b want=1", done); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL good_busy got=%b want=0", busy); end
        n_checks++; if (pass !== 1'b1)       begin n_fail++; $display("FAIL good_pass got=%b want=1", pass); end
        n_checks++; if (err_cnt !== 5'd0)    begin n_fail++; $display("FAIL good_err_cnt got=%0d want=0", err_cnt); end
        n_checks++; if (err_mask !== 3'b000) begin n_fail++; $display("FAIL good_err_mask got=%b want=000", err_mask); end
        n_checks++; if (vec_idx !== 3'd6)    begin n_fail++; $display("FAIL good_vec_idx got=%0d want=6", vec_idx); end
        n_checks++; if ({bus.dut_rst_n, bus.dut_d} !== 2'b11) begin n_fail++; $display("FAIL good_hold_last got=%b want=11", {bus.dut_rst_n, bus.dut_d}); end
        $display("good run: pass=%b err_cnt=%0d err_mask=%b", pass, err_cnt, err_mask);
    endtask

    task automatic test_latch_stuck0();
        int cyc;
        frc_en  = 3'b001;
        frc_val = 3'b000;
        pulse_start();
        wait_done(0, cyc);
        n_checks++; if (cyc !== 28)          begin n_fail++; $display("FAIL latch0_cycles got=%0d want=28", cyc); end
        n_checks++; if (err_cnt !== 5'd3)    begin n_fail++; $display("FAIL latch0_err_cnt got=%0d want=3", err_cnt); end
        n_checks++; if (err_mask !== 3'b001) begin n_fail++; $display("FAIL latch0_err_mask got=%b want=001", err_mask); end
        n_checks++; if (pass !== 1'b0)       begin n_fail++; $display("FAIL latch0_pass got=%b want=0", pass); end
        $display("latch stuck 0: cycles=%0d err_cnt=%0d err_mask=%b", cyc, err_cnt, err_mask);
    endtask

    // Start from DONE after a failing run must clear the old result at once.
    task automatic test_restart_from_done();
        int cyc;
        frc_en = 3'b000;
        pulse_start();
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL restart_done got=%b want=0", done); end
        n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL restart_busy got=%b want=1", busy); end
        n_checks++; if (err_cnt !== 5'd0)    begin n_fail++; $display("FAIL restart_err_cnt got=%0d want=0", err_cnt); end
        n_checks++; if (err_mask !== 3'b000) begin n_fail++; $display("FAIL restart_err_mask got=%b want=000", err_mask); end
        n_checks++; if (vec_idx !== 3'd0)    begin n_fail++; $display("FAIL restart_vec_idx got=%0d want=0", vec_idx); end
        wait_done(0, cyc);
        n_checks++; if (cyc !== 28)          begin n_fail++; $display("FAIL restart_cycles got=%0d want=28", cyc); end
        n_checks++; if (pass !== 1'b1)       begin n_fail++; $display("FAIL restart_pass got=%b want=1", pass); end
        $display("restart from done: cycles=%0d pass=%b", cyc, pass);
    endtask

    task automatic test_asyn_syn_stuck1();
        int cyc;
        frc_en  = 3'b110;
        frc_val = 3'b110;
        pulse_start();
        wait_done(0, cyc);
        n_checks++; if (cyc !== 28)          begin n_fail++; $display("FAIL ff1_cycles got=%0d want=28", cyc); end
        n_checks++; if (err_cnt !== 5'd8)    begin n_fail++; $display("FAIL ff1_err_cnt got=%0d want=8", err_cnt); end
        n_checks++; if (err_mask !== 3'b110) begin n_fail++; $display("FAIL ff1_err_mask got=%b want=110", err_mask); end
        n_checks++; if (pass !== 1'b0)       begin n_fail++; $display("FAIL ff1_pass got=%b want=0", pass); end
        frc_en = 3'b000;
        $display("asyn+syn stuck 1: cycles=%0d err_cnt=%0d err_mask=%b", cyc, err_cnt, err_mask);
    endtask

    task automatic test_start_while_busy();
        int cyc;
        pulse_start();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (vec_idx !== 3'd1) begin n_fail++; $display("FAIL busy_start_vec_idx got=%0d want=1", vec_idx); end
        wait_done(5, cyc);
        n_checks++; if (cyc !== 28)       begin n_fail++; $display("FAIL busy_start_cycles got=%0d want=28", cyc); end
        n_checks++; if (pass !== 1'b1)    begin n_fail++; $display("FAIL busy_start_pass got=%b want=1", pass); end
        $display("start while busy: cycles=%0d pass=%b", cyc, pass);
    endtask

    task automatic test_mid_run_reset();
        int cyc;
        pulse_start();
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0)         begin n_fail++; $display("FAIL midrst_done got=%b want=0", done); end
        n_checks++; if (vec_idx !== 3'd0)      begin n_fail++; $display("FAIL midrst_vec_idx got=%0d want=0", vec_idx); end
        n_checks++; if (bus.dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL midrst_dut_rst_n got=%b want=0", bus.dut_rst_n); end
        n_checks++; if (bus.dut_d !== 1'b0)    begin n_fail++; $display("FAIL midrst_dut_d got=%b want=0", bus.dut_d); end
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got busy=%b done=%b want 0 0", busy, done); end
        pulse_start();
        wait_done(0, cyc);
        n_checks++; if (cyc !== 28)            begin n_fail++; $display("FAIL midrst_rerun_cycles got=%0d want=28", cyc); end
        n_checks++; if (pass !== 1'b1)         begin n_fail++; $display("FAIL midrst_rerun_pass got=%b want=1", pass); end
        $display("mid-run reset then rerun: cycles=%0d pass=%b", cyc, pass);
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_latch_stuck0();
        test_restart_from_done();
        test_asyn_syn_stuck1();
        test_start_while_busy();
        test_mid_run_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
